patch_row_extractor: RTL and testbench
======================================

Name: patch_row_extractor

Overview:
- Multi-lane, multi-row successor to the single-row patch matcher.
- Watches the camera-link pixel stream, which carries PIX_PER_CLK pixels per beat from each of N_ROW buffered rows.
- After an init command, captures PATCH_SIZE consecutive pixels of one selected row, starting at a programmed column.
- Buffers the captured pixels in a lane-masked word FIFO and returns them one pixel per handshake to the downstream patch accumulator.

Parameters:
PATCH_SIZE, 6, pixels captured per patch row (1..63)
N_COL_SIZE, 12, width of column numbers
PIX_PER_CLK, 4, pixels per stream beat (power of 2, 1..8)
N_ROW, 2, number of row taps on the stream (1..8)
PIXEL_W, 12, bits per pixel
FIFO_DEPTH, 4, FIFO words, each PIX_PER_CLK lanes (power of 2, ≥2)

Ports:
cl_clk  in  1  sole clock
reset  in  1  synchronous, active-high reset
init_en  in  1  start a capture (honoured only in IDLE)
row_sel_in  in  max(1,log2(N_ROW))  row tap to capture
start_col_in  in  N_COL_SIZE  first column of patch
beat_valid  in  1  stream beat present this cycle
beat_col  in  N_COL_SIZE  column of lane 0; always a multiple of PIX_PER_CLK
pixels_in  in  N_ROW*PIX_PER_CLK*PIXEL_W  row r, lane l at bits [(r*PIX_PER_CLK+l)*PIXEL_W +: PIXEL_W]
pixel_pending  out  1  pixel output is valid
pixel  out  PIXEL_W  current output pixel
pixel_ack  in  1  consume pixel (acts only when pixel_pending=1)
busy  out  1  state ≠ IDLE
done  out  1  one-cycle pulse: last patch pixel acked
missed  out  1  sticky: start column skipped by the stream
overflow  out  1  sticky: word dropped because FIFO full

Behaviour:
- Reset: state=IDLE; FIFO and unpacker flushed; pixel_pending=0, pixel=0, busy=0, done=0, missed=0, overflow=0. Reset wins over all other inputs in the same cycle, including mid-capture.
- States:
  - IDLE: on init_en, latch row_sel, start_col and remaining=PATCH_SIZE (width log2(PATCH_SIZE+1)); clear missed and overflow; go to WAIT.
  - WAIT: on a beat_valid beat:
    - beat_col ≤ start_col < beat_col+PIX_PER_CLK: capture lanes off=start_col−beat_col through min(PIX_PER_CLK−1, off+remaining−1); remaining −= captured count. Go to CAPTURE, or to DRAIN if remaining reaches 0.
    - beat_col > start_col: set missed and return to IDLE with nothing written.
    - Otherwise stay in WAIT.
    - Compares are unsigned, N_COL_SIZE wide. beat_col+PIX_PER_CLK is computed one bit wider, so there is no wrap at the top column.
  - CAPTURE: each beat_valid beat captures lanes 0..min(PIX_PER_CLK−1, remaining−1). When remaining hits 0, go to DRAIN. Beats need not be contiguous; beat_col is not rechecked.
  - DRAIN: stay until FIFO and unpacker are empty, then pulse done for one cycle and go to IDLE.
- FIFO write (see boundaries for the full-FIFO case):
  - Each capturing beat writes one word: PIX_PER_CLK lanes of PIXEL_W plus a per-lane valid mask.
  - The write is registered at the capturing edge; pixel_pending may assert in the next cycle (first-word fall-through).
- Output unpacker:
  - Presents the lowest-indexed valid lane of the head word.
  - pixel_ack with pixel_pending clears that lane's valid bit. The next valid lane, or the next word's first valid lane, is presented in the following cycle with no bubble.
  - The word is popped when its last valid lane is acked.
  - Output order is ascending column.
  - pixel holds its value while unacked. pixel_ack with pixel_pending=0 is ignored.
- done is generated only from DRAIN. A capture ended by missed produces no done.
- Simultaneous write and pop in the same cycle is allowed, including when the FIFO is full.
- Boundaries:
  - FIFO full at write with no pop that cycle: the word is dropped, overflow is set, and remaining still decrements, so the patch still terminates.
  - init_en outside IDLE is ignored.
  - init_en arriving together with the done cycle is ignored; it is accepted one cycle after done.
- N_ROW=1 uses a 1-bit row_sel_in, which is ignored.

Test Plan:
1. Defaults; init start_col=5, row 0; beats col=0,4,8,12 → beat 4 captures lanes 1–3, beat 8 captures lanes 0–2; pixels of columns 5,6,7,8,9,10 out in order; done pulses one cycle after the sixth ack; busy then 0.
2. start_col=8, row_sel=1, distinct row data; beats 8,12 → 4 pixels from beat 8, lanes 0–1 from beat 12, all from row 1, none from row 0.
3. Init start_col=2; first beat after init col=4 → missed=1, state IDLE, pixel_pending stays 0, no done.
4. PATCH_SIZE=16, FIFO_DEPTH=2, pixel_ack held 0, beats 0,4,8,12 from start_col=0 → overflow=1 after third beat. Two words retained (cols 0–7); after those 8 acks, done pulses.
5. Reset asserted during CAPTURE with 2 words buffered → next cycle all outputs 0, FIFO empty; a new init then runs scenario 1 cleanly.
6. pixel_ack pulses while pending=0 and init_en pulses while busy → no state or output change; back-to-back ack every cycle over a word boundary → no bubble on pixel_pending.

Source files
------------

// File: rtl/patch_row_extractor.sv
// patch_row_extractor: captures PATCH_SIZE pixels of one row tap from a multi-lane
// stream into a lane-masked word FIFO and replays them one pixel per handshake.
module patch_row_extractor #(
  parameter int PATCH_SIZE = 6,
  parameter int N_COL_SIZE = 12,
  parameter int PIX_PER_CLK = 4,
  parameter int N_ROW = 2,
  parameter int PIXEL_W = 12,
  parameter int FIFO_DEPTH = 4,
  localparam int RW = N_ROW > 1 ? $clog2(N_ROW) : 1,
  localparam int CW = $clog2(PATCH_SIZE + 1),
  localparam int LW = PIX_PER_CLK > 1 ? $clog2(PIX_PER_CLK) : 1,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int WW = PIX_PER_CLK * PIXEL_W
) (
  input  logic                              cl_clk,
  input  logic                              reset,
  input  logic                              init_en,
  input  logic [RW-1:0]                     row_sel_in,
  input  logic [N_COL_SIZE-1:0]             start_col_in,
  input  logic                              beat_valid,
  input  logic [N_COL_SIZE-1:0]             beat_col,
  input  logic [N_ROW*PIX_PER_CLK*PIXEL_W-1:0] pixels_in,
  output logic                              pixel_pending,
  output logic [PIXEL_W-1:0]                pixel,
  input  logic                              pixel_ack,
  output logic                              busy,
  output logic                              done,
  output logic                              missed,
  output logic                              overflow
);
  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, DRAIN} state_t;
  state_t state_q;
  logic [RW-1:0] row_q;
  logic [N_COL_SIZE-1:0] start_q;
  logic [CW-1:0] rem_q;
  logic missed_q, overflow_q, done_q;
  logic [WW-1:0] data_q [FIFO_DEPTH];
  logic [PIX_PER_CLK-1:0] vld_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic hit, late, cap, ack, last, pop, full, push;
  logic [LW-1:0] off, sel;
  logic [PIX_PER_CLK-1:0] cap_mask, head;
  logic [CW-1:0] cap_cnt;
  logic [WW-1:0] cap_word;
  // beat_col + PIX_PER_CLK is one bit wider so the top column never wraps
  always_comb begin
    hit = beat_col <= start_q && {1'b0, start_q} < {1'b0, beat_col} + (N_COL_SIZE+1)'(PIX_PER_CLK);
    late = beat_col > start_q;
    cap = beat_valid && (state_q == CAPTURE || (state_q == WAIT && hit));
    off = state_q == WAIT ? LW'(start_q - beat_col) : '0;
    cap_mask = '0;
    cap_cnt = '0;
    for (int l = 0; l < PIX_PER_CLK; l++) begin
      cap_mask[l] = l >= int'(off) && l - int'(off) < int'(rem_q);
      cap_cnt = cap_cnt + CW'(cap_mask[l]);
    end
    cap_word = pixels_in[(N_ROW > 1 ? int'(row_q) : 0) * WW +: WW];
    head = vld_q[rd_q];
    sel = '0;
    for (int l = PIX_PER_CLK - 1; l >= 0; l--) if (head[l]) sel = LW'(l);
    pixel_pending = cnt_q != '0;
    pixel = pixel_pending ? data_q[rd_q][int'(sel) * PIXEL_W +: PIXEL_W] : '0;
    ack = pixel_ack && pixel_pending;
    last = (head & ~(PIX_PER_CLK'(1) << sel)) == '0;
    pop = ack && last;
    full = cnt_q == (AW+1)'(FIFO_DEPTH);
    push = cap && (!full || pop);
  end
  always_ff @(posedge cl_clk) begin
    if (reset) begin
      state_q <= IDLE;
      row_q <= '0;
      start_q <= '0;
      rem_q <= '0;
      missed_q <= 1'b0;
      overflow_q <= 1'b0;
      done_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (ack) vld_q[rd_q][sel] <= 1'b0;
      if (push) begin
        data_q[wr_q] <= cap_word;
        vld_q[wr_q] <= cap_mask;
        wr_q <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      if (cap && !push) overflow_q <= 1'b1;
      if (cap) rem_q <= rem_q - cap_cnt;
      case (state_q)
        IDLE: if (init_en && !done_q) begin
          row_q <= row_sel_in;
          start_q <= start_col_in;
          rem_q <= CW'(PATCH_SIZE);
          missed_q <= 1'b0;
          overflow_q <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: if (beat_valid && hit) state_q <= rem_q == cap_cnt ? DRAIN : CAPTURE;
          else if (beat_valid && late) begin
            missed_q <= 1'b1;
            state_q <= IDLE;
          end
        CAPTURE: if (cap && rem_q == cap_cnt) state_q <= DRAIN;
        default: if (cnt_q == '0) begin
          done_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign missed = missed_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_patch_row_extractor.sv
// tb_patch_row_extractor: scoreboard bench for the patch row extractor, with a
// second small-FIFO instance for the overflow scenario.
module tb_patch_row_extractor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic init_en = 1'b0;
  logic row_sel = 1'b0;
  logic [11:0] start_col = '0;
  logic beat_valid = 1'b0;
  logic [11:0] beat_col = '0;
  logic [95:0] pixels_in = '0;
  logic pixel_ack = 1'b0;
  logic pp1, bz1, dn1, ms1, ov1, pp4, bz4, dn4, ms4, ov4;
  logic [11:0] px1, px4;
  logic use4 = 1'b0;
  logic cur_pend;
  logic [11:0] cur_pix;
  logic [11:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  patch_row_extractor dut (
    .cl_clk(clk), .reset(reset), .init_en(init_en), .row_sel_in(row_sel),
    .start_col_in(start_col), .beat_valid(beat_valid), .beat_col(beat_col),
    .pixels_in(pixels_in), .pixel_pending(pp1), .pixel(px1), .pixel_ack(pixel_ack),
    .busy(bz1), .done(dn1), .missed(ms1), .overflow(ov1));

  patch_row_extractor #(.PATCH_SIZE(16), .FIFO_DEPTH(2)) dut4 (
    .cl_clk(clk), .reset(reset), .init_en(init_en), .row_sel_in(row_sel),
    .start_col_in(start_col), .beat_valid(beat_valid), .beat_col(beat_col),
    .pixels_in(pixels_in), .pixel_pending(pp4), .pixel(px4), .pixel_ack(pixel_ack),
    .busy(bz4), .done(dn4), .missed(ms4), .overflow(ov4));

  assign cur_pend = use4 ? pp4 : pp1;
  assign cur_pix = use4 ? px4 : px1;

  function automatic logic [11:0] pix(input int r, input int c);
    return 12'(r * 256 + c);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init(input logic r, input int col);
    init_en = 1'b1;
    row_sel = r;
    start_col = 12'(col);
    step();
    init_en = 1'b0;
  endtask

  task automatic beat(input int col);
    beat_valid = 1'b1;
    beat_col = 12'(col);
    for (int r = 0; r < 2; r++)
      for (int l = 0; l < 4; l++) pixels_in[(r * 4 + l) * 12 +: 12] = pix(r, col + l);
    step();
    beat_valid = 1'b0;
  endtask

  task automatic expect_cols(input int r, input int first, input int n);
    for (int c = first; c < first + n; c++) exp_q.push_back(pix(r, c));
  endtask

  task automatic drain(input bit strict);
    int guard = 0;
    bit started = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      if (cur_pend) begin
        n_checks++;
        if (cur_pix !== exp_q[0]) begin
          n_fail++;
          $display("FAIL pixel_order: got %0h want %0h", cur_pix, exp_q[0]);
        end
        void'(exp_q.pop_front());
        pixel_ack = 1'b1;
        started = 1;
      end else begin
        pixel_ack = 1'b0;
        if (strict && started) begin
          n_checks++;
          n_fail++;
          $display("FAIL no_bubble: pixel_pending got 0 want 1");
        end
      end
      step();
      guard++;
    end
    pixel_ack = 1'b0;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d pixels outstanding want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    init_en = 1'b1;
    step();
    step();
    n_checks++;
    if ({pp1, px1, bz1, dn1, ms1, ov1} !== 17'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %0h want 0", {pp1, px1, bz1, dn1, ms1, ov1});
    end
    init_en = 1'b0;
    reset = 1'b0;
    step();
    n_checks++;
    if (bz1 !== 1'b0 || pp1 !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: busy=%0b pending=%0b want 0 0", bz1, pp1);
    end
  endtask

  task automatic test_basic();
    do_init(1'b0, 5);
    n_checks++;
    if (bz1 !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_init: got %0b want 1", bz1);
    end
    beat(0);
    n_checks++;
    if (pp1 !== 1'b0) begin
      n_fail++;
      $display("FAIL early_beat_pending: got %0b want 0", pp1);
    end
    beat(4);
    expect_cols(0, 5, 3);
    n_checks++;
    if (pp1 !== 1'b1) begin
      n_fail++;
      $display("FAIL fallthrough_pending: got %0b want 1", pp1);
    end
    beat(8);
    expect_cols(0, 8, 3);
    beat(12);
    drain(1'b0);
    n_checks++;
    if (dn1 !== 1'b0 || pp1 !== 1'b0) begin
      n_fail++;
      $display("FAIL done_early: done=%0b pending=%0b want 0 0", dn1, pp1);
    end
    step();
    n_checks++;
    if (dn1 !== 1'b1 || bz1 !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: done=%0b busy=%0b want 1 0", dn1, bz1);
    end
    step();
    n_checks++;
    if (dn1 !== 1'b0) begin
      n_fail++;
      $display("FAIL done_one_cycle: got %0b want 0", dn1);
    end
  endtask

  task automatic test_row_select();
    int guard = 0;
    do_init(1'b1, 8);
    beat(8);
    beat(12);
    expect_cols(1, 8, 6);
    drain(1'b0);
    while (dn1 !== 1'b1 && guard < 10) begin
      step();
      guard++;
    end
    n_checks++;
    if (dn1 !== 1'b1) begin
      n_fail++;
      $display("FAIL row1_done: got %0b want 1", dn1);
    end
    step();
  endtask

  task automatic test_missed();
    do_init(1'b0, 2);
    beat(4);
    n_checks++;
    if (ms1 !== 1'b1 || bz1 !== 1'b0 || pp1 !== 1'b0) begin
      n_fail++;
      $display("FAIL missed: missed=%0b busy=%0b pending=%0b want 1 0 0", ms1, bz1, pp1);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (dn1 !== 1'b0 || pp1 !== 1'b0) begin
        n_fail++;
        $display("FAIL missed_quiet: done=%0b pending=%0b want 0 0", dn1, pp1);
      end
    end
  endtask

  task automatic test_overflow();
    reset = 1'b1;
    step();
    reset = 1'b0;
    use4 = 1'b1;
    do_init(1'b0, 0);
    beat(0);
    beat(4);
    n_checks++;
    if (ov4 !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_early: got %0b want 0", ov4);
    end
    beat(8);
    n_checks++;
    if (ov4 !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_set: got %0b want 1", ov4);
    end
    beat(12);
    expect_cols(0, 0, 8);
    drain(1'b0);
    step();
    n_checks++;
    if (dn4 !== 1'b1 || bz4 !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_done: done=%0b busy=%0b want 1 0", dn4, bz4);
    end
    use4 = 1'b0;
  endtask

  task automatic test_reset_mid_capture();
    reset = 1'b1;
    step();
    reset = 1'b0;
    do_init(1'b0, 3);
    beat(0);
    beat(4);
    n_checks++;
    if (bz1 !== 1'b1 || pp1 !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_capture: busy=%0b pending=%0b want 1 1", bz1, pp1);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if ({pp1, px1, bz1, dn1, ms1, ov1} !== 17'h0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %0h want 0", {pp1, px1, bz1, dn1, ms1, ov1});
    end
    step();
    n_checks++;
    if (pp1 !== 1'b0) begin
      n_fail++;
      $display("FAIL fifo_flushed: pending got %0b want 0", pp1);
    end
    test_basic();
  endtask

  task automatic test_back_to_back();
    pixel_ack = 1'b1;
    step();
    pixel_ack = 1'b0;
    n_checks++;
    if (pp1 !== 1'b0 || bz1 !== 1'b0 || px1 !== 12'h0) begin
      n_fail++;
      $display("FAIL stray_ack: pending=%0b busy=%0b pixel=%0h want 0 0 0", pp1, bz1, px1);
    end
    do_init(1'b0, 5);
    do_init(1'b1, 9);
    beat(4);
    beat(8);
    expect_cols(0, 5, 6);
    drain(1'b1);
    step();
    n_checks++;
    if (dn1 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done: got %0b want 1", dn1);
    end
    do_init(1'b0, 5);
    n_checks++;
    if (bz1 !== 1'b0) begin
      n_fail++;
      $display("FAIL init_on_done: busy got %0b want 0", bz1);
    end
    do_init(1'b0, 5);
    n_checks++;
    if (bz1 !== 1'b1) begin
      n_fail++;
      $display("FAIL init_after_done: busy got %0b want 1", bz1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_row_select();
    test_missed();
    test_overflow();
    test_reset_mid_capture();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
